sort_job_ctrl: RTL and testbench

SORT_JOB_CTRL -- requirements
Module: sort_job_ctrl

---
 rtl/sort_job_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_sort_job_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_job_ctrl.sv
// Job sequencer around an external RAM-based sorter: loads DEPTH words, runs the sort, then drains the
// sorted words on a valid/ready stream. Optional sort watchdog is enabled by defining SORT_JOB_TIMEOUT_EN.
module sort_job_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic                  busy,
    output logic                  job_done,
    output logic                  err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  srt_s,
    output logic                  srt_wrin,
    output logic                  srt_rd,
    output logic [ADDR_WIDTH-1:0] srt_radd,
    output logic [DATA_WIDTH-1:0] srt_datain,
    input  logic                  srt_done,
    input  logic [DATA_WIDTH-1:0] srt_dout
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SORT, S_RELEASE, S_RD, S_CAP, S_OUT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                  r_state, w_state_next;
    logic [ADDR_WIDTH-1:0]   r_cnt, w_cnt_next;
    logic                    r_out_valid, w_out_valid_next;
    logic [DATA_WIDTH-1:0]   r_out_data, w_out_data_next;
    logic                    r_out_last, w_out_last_next;
    logic                    r_job_done, w_job_done_next;
    logic                    r_srt_s;

`ifdef SORT_JOB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_tmo, w_tmo_next;
    logic             r_err, w_err_next;
    logic             r_abort, w_abort_next;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_job_done  <= 1'b0;
            r_srt_s     <= 1'b0;
`ifdef SORT_JOB_TIMEOUT_EN
            r_tmo       <= '0;
            r_err       <= 1'b0;
            r_abort     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_out_valid <= w_out_valid_next;
            r_out_data  <= w_out_data_next;
            r_out_last  <= w_out_last_next;
            r_job_done  <= w_job_done_next;
            r_srt_s     <= (w_state_next == S_SORT);
`ifdef SORT_JOB_TIMEOUT_EN
            r_tmo       <= w_tmo_next;
            r_err       <= w_err_next;
            r_abort     <= w_abort_next;
`endif
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_out_valid_next = r_out_valid;
        w_out_data_next  = r_out_data;
        w_out_last_next  = r_out_last;
        w_job_done_next  = 1'b0;
`ifdef SORT_JOB_TIMEOUT_EN
        w_tmo_next       = r_tmo;
        w_err_next       = r_err;
        w_abort_next     = r_abort;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_LOAD;
                    w_cnt_next   = '0;
`ifdef SORT_JOB_TIMEOUT_EN
                    w_err_next   = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == LAST_ADDR) begin
                        w_state_next = S_SORT;
`ifdef SORT_JOB_TIMEOUT_EN
                        w_tmo_next   = '0;
`endif
                    end
                end
            end
            S_SORT: begin
                if (srt_done) begin
                    w_state_next = S_RELEASE;
`ifdef SORT_JOB_TIMEOUT_EN
                end else if (r_tmo == TMO_LAST) begin
                    // Watchdog expiry: still pass through RELEASE so srt_s drops cleanly, then abandon.
                    w_state_next = S_RELEASE;
                    w_err_next   = 1'b1;
                    w_abort_next = 1'b1;
                end else begin
                    w_tmo_next   = r_tmo + 1'b1;
`endif
                end
            end
            S_RELEASE: begin
                w_state_next = S_RD;
`ifdef SORT_JOB_TIMEOUT_EN
                if (r_abort) begin
                    w_state_next = S_IDLE;
                    w_abort_next = 1'b0;
                end
`endif
            end
            S_RD: begin
                w_state_next = S_CAP;
            end
            S_CAP: begin
                w_out_data_next  = srt_dout;
                w_out_valid_next = 1'b1;
                w_out_last_next  = (r_cnt == LAST_ADDR);
                w_state_next     = S_OUT;
            end
            S_OUT: begin
                // out_valid is always high here, so out_ready alone marks the handshake.
                if (out_ready) begin
                    w_out_valid_next = 1'b0;
                    if (r_out_last) begin
                        w_state_next    = S_IDLE;
                        w_job_done_next = 1'b1;
                        w_cnt_next      = '0;
                    end else begin
                        w_cnt_next   = r_cnt + 1'b1;
                        w_state_next = S_RD;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Sorter host port is steered combinationally from the current state.
    always_comb begin
        srt_wrin   = 1'b0;
        srt_rd     = 1'b0;
        srt_radd   = '0;
        srt_datain = '0;
        case (r_state)
            S_LOAD: begin
                srt_wrin   = in_valid;
                srt_radd   = r_cnt;
                srt_datain = in_data;
            end
            S_RD, S_CAP: begin
                srt_rd   = 1'b1;
                srt_radd = r_cnt;
            end
            default: begin
                srt_wrin = 1'b0;
            end
        endcase
    end

    assign busy      = (r_state != S_IDLE);
    assign in_ready  = (r_state == S_LOAD);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign job_done  = r_job_done;
    assign srt_s     = r_srt_s;

`ifdef SORT_JOB_TIMEOUT_EN
    assign err = r_err;
`else
    // No watchdog in this build; the parameter is still referenced so both builds share one parameter list.
    assign err = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_sort_job_ctrl.sv
// Self-checking bench for sort_job_ctrl: table-driven directed jobs, hand sequences for reset and
// watchdog corners, and randomized jobs checked against a sort-based reference model.
module tb_sort_job_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
`ifdef SORT_JOB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    typedef logic [DW-1:0] word_arr_t [DEPTH];
    typedef struct {
        word_arr_t din;
        word_arr_t dexp;
        bit        gaps;
        int        stall_at;
        int        stall_len;
        bit        poke;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b1;
    logic          srt_done = 1'b0;
    logic [DW-1:0] srt_dout = '0;
    logic          busy, job_done, err, in_ready, out_valid, out_last;
    logic [DW-1:0] out_data, srt_datain;
    logic          srt_s, srt_wrin, srt_rd;
    logic [AW-1:0] srt_radd;

    always #5 clk = ~clk;

    sort_job_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .job_done(job_done), .err(err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .srt_s(srt_s), .srt_wrin(srt_wrin), .srt_rd(srt_rd), .srt_radd(srt_radd),
        .srt_datain(srt_datain), .srt_done(srt_done), .srt_dout(srt_dout)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural sorter: RAM with registered read; sorts a few cycles after srt_s rises.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] sq [$];
    int            srt_cyc = 0;
    bit            stuck_done = 1'b0;

    always @(posedge clk) begin
        if (srt_wrin) mem[srt_radd] <= srt_datain;
        if (srt_rd) srt_dout <= mem[srt_radd];
        if (!srt_s) begin
            srt_cyc  <= 0;
            srt_done <= 1'b0;
        end else if (!stuck_done) begin
            srt_cyc <= srt_cyc + 1;
            if (srt_cyc == 2) begin
                sq.delete();
                foreach (mem[i]) sq.push_back(mem[i]);
                sq.sort();
                foreach (mem[i]) mem[i] <= sq[i];
                srt_done <= 1'b1;
            end
        end
    end

    // Output monitor / scoreboard, sampled mid-cycle.
    logic [DW-1:0] got_q [$];
    int            done_cnt = 0;
    bit            any_valid = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (out_valid) any_valid = 1'b1;
            check("wr_rd_exclusive", longint'(srt_wrin && srt_rd), 0);
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
                check("hold_last", out_last, prev_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                check("out_last_flag", out_last, longint'(got_q.size() == DEPTH));
            end
            if (job_done) done_cnt++;
        end
    end

    // out_ready driver: optional scripted stall at a given word, otherwise always or random ready.
    int stall_at = -1;
    int stall_left = 0;
    bit rand_rdy = 1'b0;
    bit rand_gaps = 1'b0;

    always @(posedge clk) begin
        #1;
        if (out_valid && got_q.size() == stall_at && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_job_done"}, job_done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_srt_s"}, srt_s, 0);
        check({tag, "_srt_wrin"}, srt_wrin, 0);
        check({tag, "_srt_rd"}, srt_rd, 0);
        check({tag, "_srt_radd"}, srt_radd, 0);
        check({tag, "_srt_datain"}, srt_datain, 0);
    endtask

    task automatic start_and_load(input word_arr_t w, input bit gaps, input string tag);
        got_q.delete();
        done_cnt = 0;
        any_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_err_clear"}, err, 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (gaps || (rand_gaps && $urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                @(negedge clk);
                check({tag, "_gap_wrin"}, srt_wrin, 0);
                check({tag, "_gap_addr"}, srt_radd, i);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = w[i];
            @(negedge clk);
            check({tag, "_in_ready"}, in_ready, 1);
            check({tag, "_ld_addr"}, srt_radd, i);
            check({tag, "_ld_wrin"}, srt_wrin, 1);
            check({tag, "_ld_data"}, srt_datain, w[i]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check({tag, "_in_ready_off"}, in_ready, 0);
        check({tag, "_srt_s_on"}, srt_s, 1);
    endtask

    task automatic run_job(input word_arr_t w, input word_arr_t e, input bit gaps, input bit poke,
                           input string tag);
        int n;
        start_and_load(w, gaps, tag);
        n = 0;
        while (done_cnt == 0 && n < 600) begin
            @(posedge clk); #1;
            start = poke && busy;
            n++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, longint'(done_cnt > 0), 1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_idle_after"}, busy, 0);
        check({tag, "_word_count"}, got_q.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            if (i < got_q.size()) check({tag, "_word"}, got_q[i], e[i]);
        end
    endtask

    vec_t tbl [4];

    initial begin
        tbl[0].din  = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
        tbl[0].dexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9};
        tbl[0].gaps = 1'b0; tbl[0].stall_at = -1; tbl[0].stall_len = 0; tbl[0].poke = 1'b0;
        tbl[1].din  = tbl[0].din;
        tbl[1].dexp = tbl[0].dexp;
        tbl[1].gaps = 1'b1; tbl[1].stall_at = -1; tbl[1].stall_len = 0; tbl[1].poke = 1'b0;
        tbl[2].din  = '{8'd0, 8'd255, 8'd5, 8'd5, 8'd128, 8'd1, 8'd254, 8'd0};
        tbl[2].dexp = '{8'd0, 8'd0, 8'd1, 8'd5, 8'd5, 8'd128, 8'd254, 8'd255};
        tbl[2].gaps = 1'b0; tbl[2].stall_at = 3; tbl[2].stall_len = 5; tbl[2].poke = 1'b0;
        tbl[3].din  = '{8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        tbl[3].dexp = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        tbl[3].gaps = 1'b0; tbl[3].stall_at = -1; tbl[3].stall_len = 0; tbl[3].poke = 1'b1;

        #2;
        check_reset_vals("por");
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        foreach (tbl[k]) begin
            stall_at   = tbl[k].stall_at;
            stall_left = tbl[k].stall_len;
            run_job(tbl[k].din, tbl[k].dexp, tbl[k].gaps, tbl[k].poke, $sformatf("vec%0d", k));
        end
        stall_at = -1;
        stall_left = 0;

        // Reset in the middle of a load: everything returns to reset values immediately.
        begin
            word_arr_t w;
            got_q.delete();
            @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int i = 0; i < 4; i++) begin
                in_valid = 1'b1;
                in_data  = 8'(i + 40);
                @(posedge clk); #1;
            end
            in_data = 8'd99;
            #2;
            rstn = 1'b0;
            #1;
            check_reset_vals("rst_mid");
            in_valid = 1'b0;
            @(posedge clk); #1;
            rstn = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            check("rst_no_output", got_q.size(), 0);
            check("rst_idle", busy, 0);
            w = '{8'd200, 8'd17, 8'd99, 8'd3, 8'd64, 8'd17, 8'd250, 8'd1};
            run_job(w, '{8'd1, 8'd3, 8'd17, 8'd17, 8'd64, 8'd99, 8'd200, 8'd250}, 1'b0, 1'b0, "post_rst");
        end

        // Randomized jobs against the sort-based reference model.
        rand_rdy  = 1'b1;
        rand_gaps = 1'b1;
        for (int j = 0; j < 6; j++) begin
            word_arr_t w;
            word_arr_t e;
            logic [DW-1:0] q [$];
            q.delete();
            for (int i = 0; i < DEPTH; i++) begin
                w[i] = DW'($urandom);
                q.push_back(w[i]);
            end
            q.sort();
            for (int i = 0; i < DEPTH; i++) e[i] = q[i];
            run_job(w, e, 1'b0, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", j));
        end
        rand_rdy  = 1'b0;
        rand_gaps = 1'b0;

`ifdef SORT_JOB_TIMEOUT_EN
        // Sorter never answers: watchdog fires after TMO SORT cycles and the job is dropped.
        begin
            int hi;
            int n;
            stuck_done = 1'b1;
            start_and_load(tbl[0].din, 1'b0, "tmo");
            hi = 0;
            n  = 0;
            while (n < 200 && !(hi > 0 && !srt_s)) begin
                @(negedge clk);
                if (srt_s) hi++;
                n++;
            end
            check("tmo_sort_cycles", hi, TMO);
            check("tmo_err_set", err, 1);
            repeat (2) @(negedge clk);
            check("tmo_idle", busy, 0);
            check("tmo_err_sticky", err, 1);
            check("tmo_no_out_valid", any_valid, 0);
            check("tmo_no_done", done_cnt, 0);
            stuck_done = 1'b0;
            run_job(tbl[0].din, tbl[0].dexp, 1'b0, 1'b0, "tmo_recover");
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
